// File: rtl/uart_alu_sequencer.sv
// Frame sequencer between the UART FIFOs and the ALU: pops A, B, OPCODE, runs the ALU, pushes one reply byte.
// Optional inter-byte timeout is enabled by defining UART_SEQ_TIMEOUT_EN.
module uart_alu_sequencer #(
    parameter int              NBIT        = 8,
    parameter int              NOP         = 6,
    parameter int              ALU_LAT     = 1,
    parameter logic [NBIT-1:0] ERR_CODE    = NBIT'(8'hEE),
    parameter int              TIMEOUT_CYC = 50000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            rx_empty,
    input  logic [NBIT-1:0] r_data,
    output logic            rd_uart,
    input  logic            tx_full,
    output logic [NBIT-1:0] w_data,
    output logic            wr_uart,
    output logic [NBIT-1:0] alu_a,
    output logic [NBIT-1:0] alu_b,
    output logic [NOP-1:0]  alu_op,
    input  logic [NBIT-1:0] alu_res,
    output logic            busy,
    output logic            err,
    output logic [7:0]      frame_cnt
);

    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [NOP-1:0] OP_ADD = NOP'(6'h20);
    localparam logic [NOP-1:0] OP_SUB = NOP'(6'h22);
    localparam logic [NOP-1:0] OP_AND = NOP'(6'h24);
    localparam logic [NOP-1:0] OP_OR  = NOP'(6'h25);
    localparam logic [NOP-1:0] OP_XOR = NOP'(6'h26);
    localparam logic [NOP-1:0] OP_NOR = NOP'(6'h27);
    localparam logic [NOP-1:0] OP_SRA = NOP'(6'h03);
    localparam logic [NOP-1:0] OP_SRL = NOP'(6'h02);

    typedef enum logic [2:0] {RD_A, RD_B, RD_OP, EXEC, WR} state_t;

    state_t            state_q, state_d;
    logic [NBIT-1:0]   a_q, b_q, w_data_q;
    logic [NOP-1:0]    op_q;
    logic              op_ok_q;
    logic [LAT_W-1:0]  lat_q;
    logic [7:0]        frame_cnt_q;
    logic              exec_done;
    logic              timeout_hit;

    function automatic logic is_valid_op(input logic [NBIT-1:0] code);
        logic [NOP-1:0] f;
        f = code[NOP-1:0];
        if ((code >> NOP) != '0) return 1'b0;
        case (f)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign exec_done = (state_q == EXEC) && (lat_q == '0);

`ifdef UART_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            waiting;

    // Counts consecutive empty cycles mid-frame; any pop or leaving RD_B/RD_OP clears it.
    assign waiting     = ((state_q == RD_B) || (state_q == RD_OP)) && rx_empty;
    assign timeout_hit = waiting && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK) begin
        if (RESET || !waiting || timeout_hit) to_cnt_q <= '0;
        else                                  to_cnt_q <= to_cnt_q + TO_W'(1);
    end
`else
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= RD_A;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RD_A:  if (!rx_empty) state_d = RD_B;
            RD_B:  if (!rx_empty) state_d = RD_OP;
                   else if (timeout_hit) state_d = RD_A;
            RD_OP: if (!rx_empty) state_d = EXEC;
                   else if (timeout_hit) state_d = RD_A;
            EXEC:  if (lat_q == '0) state_d = WR;
            WR:    if (!tx_full) state_d = RD_A;
            default: state_d = RD_A;
        endcase
    end

    always_comb begin
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        busy    = 1'b0;
        err     = 1'b0;
        if (!RESET) begin
            unique case (state_q)
                RD_A:        rd_uart = !rx_empty;
                RD_B, RD_OP: begin
                    busy    = 1'b1;
                    rd_uart = !rx_empty;
                    err     = timeout_hit;
                end
                EXEC: begin
                    busy = 1'b1;
                    err  = exec_done && !op_ok_q;
                end
                WR: begin
                    busy    = 1'b1;
                    wr_uart = !tx_full;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            op_ok_q     <= 1'b0;
            lat_q       <= '0;
            w_data_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (rd_uart) begin
                unique case (state_q)
                    RD_A:  a_q <= r_data;
                    RD_B:  b_q <= r_data;
                    RD_OP: begin
                        op_ok_q <= is_valid_op(r_data);
                        if (is_valid_op(r_data)) op_q <= r_data[NOP-1:0];
                    end
                    default: ;
                endcase
            end
            if ((state_q == RD_OP) && rd_uart)      lat_q <= LAT_W'(ALU_LAT - 1);
            else if ((state_q == EXEC) && !exec_done) lat_q <= lat_q - LAT_W'(1);
            // Reply byte is frozen here so it stays stable for the whole WR wait.
            if (exec_done) w_data_q <= op_ok_q ? alu_res : ERR_CODE;
            if (wr_uart)   frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign w_data    = w_data_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Scoreboard bench for uart_alu_sequencer: queue-based RX FIFO, behavioural ALU, reply/err/frame_cnt checks.
module tb_uart_alu_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart;
    logic       tx_full = 1'b0;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [7:0] alu_a, alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_res;
    logic       busy, err;
    logic [7:0] frame_cnt;

    uart_alu_sequencer #(.TIMEOUT_CYC(20)) dut (
        .CLK(CLK), .RESET(RESET), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_res(alu_res), .busy(busy), .err(err), .frame_cnt(frame_cnt)
    );

    initial forever #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [7:0] rxq[$];
    logic [7:0] expq[$];
    int  err_exp = 0, err_seen = 0, model_cnt = 0;
    int  pops = 0, pushes = 0, cyc = 0, last_pop_cyc = 0;
    bit  chk_lat = 0, tx_force = 0, tx_rand = 0;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h03: return 8'($signed(a) >>> b[2:0]);
            6'h02: return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    assign alu_res = alu_fn(alu_a, alu_b, alu_op);

    function automatic bit ref_valid(input logic [7:0] op);
        return (op[7:6] == 2'b00) &&
               (op[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02});
    endfunction

    function automatic logic [7:0] ref_resp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        return ref_valid(op) ? alu_fn(a, b, op[5:0]) : 8'hEE;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_rx_empty();
        int n = 0;
        while (rxq.size() != 0 && n < 300) begin tick(); n++; end
        if (n >= 300) check("rx_drain_timeout", 1, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || rxq.size() != 0 || busy) && n < 600) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 600) check("drain_timeout", 1, 0);
        tick();
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input int gap);
        logic [7:0] bytes[3];
        bytes[0] = a; bytes[1] = b; bytes[2] = op;
        expq.push_back(ref_resp(a, b, op));
        if (!ref_valid(op)) err_exp++;
        tick();
        for (int i = 0; i < 3; i++) begin
            rxq.push_back(bytes[i]);
            if (gap > 0 && i < 2) begin
                wait_rx_empty();
                repeat (gap) tick();
            end
        end
    endtask

    // RX FIFO model (first-word-fall-through) and TX full driver
    initial begin
        bit do_pop;
        forever begin
            @(negedge CLK);
            do_pop = rd_uart;
            @(posedge CLK);
            #1;
            if (do_pop && rxq.size() > 0) void'(rxq.pop_front());
            #1;
            rx_empty = (rxq.size() == 0);
            r_data   = (rxq.size() > 0) ? rxq[0] : 8'h00;
            tx_full  = tx_rand ? ($urandom_range(0, 2) == 0) : tx_force;
        end
    end

    // Monitor: scoreboard pop on every push, handshake rules, err pulses
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge CLK);
            cyc++;
            if (err) err_seen++;
            if (rd_uart) begin
                pops++;
                last_pop_cyc = cyc;
                check("pop_while_empty", rx_empty, 0);
            end
            if (wr_uart) begin
                pushes++;
                check("push_while_full", tx_full, 0);
                if (expq.size() == 0) check("unexpected_push", 1, 0);
                else begin
                    exp_b = expq.pop_front();
                    check("w_data", w_data, exp_b);
                end
                check("frame_cnt_at_push", frame_cnt, model_cnt[7:0]);
                model_cnt++;
                if (chk_lat) check("op_to_push_latency", cyc - last_pop_cyc, 2);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, p0, n0;
        logic [7:0] vops[8];
        logic [7:0] ra, rb, rop;
        vops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

        repeat (3) tick();
        @(negedge CLK);
        check("rst_rd_uart", rd_uart, 0);
        check("rst_wr_uart", wr_uart, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_w_data", w_data, 0);
        check("rst_alu_a", alu_a, 0);
        tick();
        RESET = 1'b0;

        // 1: back-to-back ADD with latency check
        chk_lat = 1;
        send_frame(8'h05, 8'h03, 8'h20, 0);
        drain();
        chk_lat = 0;
        check("t1_alu_a", alu_a, 8'h05);
        check("t1_alu_b", alu_b, 8'h03);
        check("t1_alu_op", alu_op, 6'h20);
        check("t1_frame_cnt", frame_cnt, 1);

        // 2: invalid opcode
        e0 = err_seen;
        send_frame(8'h0F, 8'h01, 8'h3F, 0);
        drain();
        check("t2_err_pulses", err_seen - e0, 1);
        check("t2_alu_op_held", alu_op, 6'h20);
        check("t2_frame_cnt", frame_cnt, 2);

        // 3: TX full holds the reply
        p0 = pushes;
        tx_force = 1;
        send_frame(8'h0A, 8'h04, 8'h22, 0);
        repeat (15) tick();
        check("t3_no_push_while_full", pushes - p0, 0);
        check("t3_busy_in_wr", busy, 1);
        tx_force = 0;
        drain();
        check("t3_one_push", pushes - p0, 1);

        // 4: slow RX with 7-cycle gaps
        n0 = pops;
        send_frame(8'hF0, 8'h0F, 8'h25, 7);
        drain();
        check("t4_pop_count", pops - n0, 3);

        // 5: reset mid-frame
        tick();
        rxq.push_back(8'h11);
        rxq.push_back(8'h22);
        wait_rx_empty();
        tick();
        RESET = 1'b1;
        tick();
        tick();
        @(negedge CLK);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rd_uart", rd_uart, 0);
        check("t5_rst_alu_a", alu_a, 0);
        check("t5_rst_alu_b", alu_b, 0);
        check("t5_rst_frame_cnt", frame_cnt, 0);
        model_cnt = 0;
        tick();
        RESET = 1'b0;
        send_frame(8'h01, 8'h02, 8'h20, 0);
        drain();
        check("t5_frame_cnt", frame_cnt, 1);

`ifdef UART_SEQ_TIMEOUT_EN
        // 6: inter-byte timeout
        e0 = err_seen;
        p0 = pushes;
        err_exp++;
        tick();
        rxq.push_back(8'h01);
        repeat (26) tick();
        check("t6_timeout_err", err_seen - e0, 1);
        check("t6_no_push", pushes - p0, 0);
        check("t6_idle", busy, 0);
        send_frame(8'h02, 8'h03, 8'h20, 0);
        drain();
        check("t6_frame_cnt", frame_cnt, 2);
`endif

        // randomized frames with gaps and random TX back-pressure
        tx_rand = 1;
        for (int i = 0; i < 40; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = ($urandom_range(0, 3) != 0) ? vops[$urandom_range(0, 7)] : 8'($urandom);
            send_frame(ra, rb, rop, $urandom_range(0, 3));
        end
        drain();
        tx_rand = 0;

        check("end_err_count", err_seen, err_exp);
        check("end_scoreboard_empty", expq.size(), 0);
        check("end_frame_cnt", frame_cnt, model_cnt[7:0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
